// File: rtl/rv_rf_sb.sv
// rv_rf_sb: integer register file with a per-register busy scoreboard.
// Two read ports with write bypass, one write port, one issue port.
module rv_rf_sb #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int AW       = $clog2(NUM_REGS),
   parameter int READ_REG = 0,
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rd_addr1_i,
   input  logic [AW-1:0]   rd_addr2_i,
   output logic [XLEN-1:0] rd_data1_o,
   output logic [XLEN-1:0] rd_data2_o,
   output logic            rd_busy1_o,
   output logic            rd_busy2_o,
   input  logic            wr_en_i,
   input  logic [AW-1:0]   wr_addr_i,
   input  logic [XLEN-1:0] wr_data_i,
   input  logic            iss_en_i,
   input  logic [AW-1:0]   iss_addr_i,
   output logic            busy_any_o
);

   localparam logic HAS_ZERO = (ZERO_REG != 0);

   logic [XLEN-1:0]     regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;

   logic wr_ok;
   logic iss_ok;

   logic [AW-1:0]   rd_addr [2];
   logic [XLEN-1:0] rd_data [2];
   logic            rd_busy [2];

   // Writes and issues aimed at a hardwired zero register are dropped.
   assign wr_ok  = wr_en_i && !(HAS_ZERO && wr_addr_i == '0);
   assign iss_ok = iss_en_i && !(HAS_ZERO && iss_addr_i == '0);

   assign rd_addr[0] = rd_addr1_i;
   assign rd_addr[1] = rd_addr2_i;

   // Data array: cleared on reset, written by writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[wr_addr_i] <= wr_data_i;
      end
   end

   // Scoreboard: writeback clears, issue sets; issue is last so it wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (wr_ok) begin
            busy[wr_addr_i] <= 1'b0;
         end
         if (iss_ok) begin
            busy[iss_addr_i] <= 1'b1;
         end
      end
   end

   // Read lookup per port: zero register, then writeback bypass, then array.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs[rd_addr[p]];
         rd_busy[p] = busy[rd_addr[p]];
         if (HAS_ZERO && rd_addr[p] == '0) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end else if (wr_en_i && wr_addr_i == rd_addr[p]) begin
            rd_data[p] = wr_data_i;
            rd_busy[p] = 1'b0;
         end
      end
   end

   generate
      if (READ_REG != 0) begin : g_rd_reg
         // Registered read: lookup result captured for one cycle of latency.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data1_o <= '0;
               rd_data2_o <= '0;
               rd_busy1_o <= 1'b0;
               rd_busy2_o <= 1'b0;
            end else begin
               rd_data1_o <= rd_data[0];
               rd_data2_o <= rd_data[1];
               rd_busy1_o <= rd_busy[0];
               rd_busy2_o <= rd_busy[1];
            end
         end
      end else begin : g_rd_comb
         assign rd_data1_o = rd_data[0];
         assign rd_data2_o = rd_data[1];
         assign rd_busy1_o = rd_busy[0];
         assign rd_busy2_o = rd_busy[1];
      end
   endgenerate

   // Drain indicator reflects stored state only, not the bypass.
   assign busy_any_o = |busy;

endmodule

// File: tb/tb_rv_rf_sb.sv
// tb_rv_rf_sb: directed and random checks of two rv_rf_sb configurations
// against a behavioural model through expectation queues.
module tb_rv_rf_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  ra1, ra2, wa, ia;
   logic        we, ie;
   logic [63:0] wd;

   logic [31:0] d0_1, d0_2;
   logic        b0_1, b0_2, ba0;
   logic [63:0] d1_1, d1_2;
   logic        b1_1, b1_2, ba1;

   rv_rf_sb dut0 (
      .clk(clk), .rst(rst),
      .rd_addr1_i(ra1), .rd_addr2_i(ra2),
      .rd_data1_o(d0_1), .rd_data2_o(d0_2),
      .rd_busy1_o(b0_1), .rd_busy2_o(b0_2),
      .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd[31:0]),
      .iss_en_i(ie), .iss_addr_i(ia),
      .busy_any_o(ba0)
   );

   rv_rf_sb #(.XLEN(64), .NUM_REGS(16), .READ_REG(1)) dut1 (
      .clk(clk), .rst(rst),
      .rd_addr1_i(ra1[3:0]), .rd_addr2_i(ra2[3:0]),
      .rd_data1_o(d1_1), .rd_data2_o(d1_2),
      .rd_busy1_o(b1_1), .rd_busy2_o(b1_2),
      .wr_en_i(we), .wr_addr_i(wa[3:0]), .wr_data_i(wd),
      .iss_en_i(ie), .iss_addr_i(ia[3:0]),
      .busy_any_o(ba1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] d1;
      logic [63:0] d2;
      logic        b1;
      logic        b2;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   logic [31:0] m0  [32];
   logic        m0b [32];
   logic [63:0] m1  [16];
   logic        m1b [16];

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] rp0(logic [4:0] a);
      if (a == 5'd0) return '0;
      if (we && wa == a) return {1'b0, 32'd0, wd[31:0]};
      return {m0b[a], 32'd0, m0[a]};
   endfunction

   function automatic logic [64:0] rp1(logic [3:0] a);
      if (a == 4'd0) return '0;
      if (we && wa[3:0] == a) return {1'b0, wd};
      return {m1b[a], m1[a]};
   endfunction

   function automatic logic any0();
      logic r = 1'b0;
      for (int i = 0; i < 32; i++) r |= m0b[i];
      return r;
   endfunction

   function automatic logic any1();
      logic r = 1'b0;
      for (int i = 0; i < 16; i++) r |= m1b[i];
      return r;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin
         m0[i]  = '0;
         m0b[i] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         m1[i]  = '0;
         m1b[i] = 1'b0;
      end
   endtask

   // One clock cycle: check at negedge, then advance the model at posedge.
   task automatic cyc(string tag,
                      logic [4:0] a1, logic [4:0] a2,
                      logic w, logic [4:0] wad, logic [63:0] wdat,
                      logic i, logic [4:0] iad);
      exp_t e0, e1, x;
      logic [64:0] r;
      ra1 = a1; ra2 = a2;
      we = w; wa = wad; wd = wdat;
      ie = i; ia = iad;
      r = rp0(a1); e0.d1 = r[63:0]; e0.b1 = r[64];
      r = rp0(a2); e0.d2 = r[63:0]; e0.b2 = r[64];
      r = rp1(a1[3:0]); e1.d1 = r[63:0]; e1.b1 = r[64];
      r = rp1(a2[3:0]); e1.d2 = r[63:0]; e1.b2 = r[64];
      q0.push_back(e0);
      @(negedge clk);
      x = q0.pop_front();
      chk({tag, ".c.d1"}, {32'd0, d0_1}, x.d1);
      chk({tag, ".c.d2"}, {32'd0, d0_2}, x.d2);
      chk({tag, ".c.b1"}, {63'd0, b0_1}, {63'd0, x.b1});
      chk({tag, ".c.b2"}, {63'd0, b0_2}, {63'd0, x.b2});
      chk({tag, ".c.any"}, {63'd0, ba0}, {63'd0, any0()});
      x = q1.pop_front();
      chk({tag, ".r.d1"}, d1_1, x.d1);
      chk({tag, ".r.d2"}, d1_2, x.d2);
      chk({tag, ".r.b1"}, {63'd0, b1_1}, {63'd0, x.b1});
      chk({tag, ".r.b2"}, {63'd0, b1_2}, {63'd0, x.b2});
      chk({tag, ".r.any"}, {63'd0, ba1}, {63'd0, any1()});
      q1.push_back(e1);
      @(posedge clk);
      if (w) begin
         if (wad != 5'd0) begin
            m0[wad]  = wdat[31:0];
            m0b[wad] = 1'b0;
         end
         if (wad[3:0] != 4'd0) begin
            m1[wad[3:0]]  = wdat;
            m1b[wad[3:0]] = 1'b0;
         end
      end
      if (i) begin
         if (iad != 5'd0) m0b[iad] = 1'b1;
         if (iad[3:0] != 4'd0) m1b[iad[3:0]] = 1'b1;
      end
      #1;
   endtask

   task automatic rd(string tag, logic [4:0] a1, logic [4:0] a2);
      cyc(tag, a1, a2, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset(string tag);
      exp_t z;
      z.d1 = '0; z.d2 = '0; z.b1 = 1'b0; z.b2 = 1'b0;
      we = 1'b0; ie = 1'b0;
      rst = 1'b1;
      #2;
      chk({tag, ".c.d1"}, {32'd0, d0_1}, 64'd0);
      chk({tag, ".c.b1"}, {63'd0, b0_1}, 64'd0);
      chk({tag, ".c.any"}, {63'd0, ba0}, 64'd0);
      chk({tag, ".r.d1"}, d1_1, 64'd0);
      chk({tag, ".r.b2"}, {63'd0, b1_2}, 64'd0);
      chk({tag, ".r.any"}, {63'd0, ba1}, 64'd0);
      clear_model();
      q0.delete();
      q1.delete();
      q1.push_back(z);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ra1 = '0; ra2 = '0; wa = '0; ia = '0;
      we = 1'b0; ie = 1'b0; wd = '0;
      clear_model();

      do_reset("rst0");
      for (int i = 0; i < 32; i++) begin
         rd($sformatf("rdall%0d", i), 5'(i), 5'(31 - i));
      end

      cyc("w5", 5'd0, 5'd0, 1'b1, 5'd5, 64'h0123_4567_DEAD_BEEF, 1'b0, 5'd0);
      rd("r5", 5'd5, 5'd5);
      rd("r5b", 5'd5, 5'd5);
      cyc("w0", 5'd0, 5'd0, 1'b1, 5'd0, 64'h1234, 1'b0, 5'd0);
      rd("r0", 5'd0, 5'd0);

      cyc("byp7", 5'd7, 5'd3, 1'b1, 5'd7, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 5'd0);
      rd("r7", 5'd7, 5'd7);

      cyc("iss3", 5'd3, 5'd5, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3);
      rd("busy3", 5'd3, 5'd3);
      cyc("wb3", 5'd3, 5'd3, 1'b1, 5'd3, 64'h55, 1'b0, 5'd0);
      rd("clr3", 5'd3, 5'd0);

      cyc("iw9", 5'd9, 5'd0, 1'b1, 5'd9, 64'h77, 1'b1, 5'd9);
      rd("r9", 5'd9, 5'd9);
      cyc("reiss9", 5'd9, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
      rd("r9b", 5'd9, 5'd9);
      cyc("wb9", 5'd9, 5'd9, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0);
      cyc("iss0", 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0);
      rd("r0b", 5'd0, 5'd9);

      cyc("w15", 5'd15, 5'd0, 1'b1, 5'd15, 64'hFFFF_0000_FFFF_0000, 1'b0, 5'd0);
      rd("r15", 5'd15, 5'd15);
      rd("r15b", 5'd0, 5'd15);

      cyc("iw_diff", 5'd4, 5'd6, 1'b1, 5'd6, 64'hCAFE, 1'b1, 5'd4);
      rd("diff", 5'd4, 5'd6);
      cyc("iss20", 5'd20, 5'd4, 1'b0, 5'd0, 64'd0, 1'b1, 5'd20);
      do_reset("rst1");
      rd("postrst", 5'd5, 5'd4);
      rd("postrst2", 5'd20, 5'd15);

      for (int n = 0; n < 300; n++) begin
         cyc($sformatf("rnd%0d", n),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom), 5'($urandom_range(0, 31)),
             {$urandom, $urandom},
             1'($urandom), 5'($urandom_range(0, 31)));
      end
      rd("final", 5'd1, 5'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_rf_sb.md
Name: rv_rf_sb

Overview:
- Parametrised integer register file with a per-register busy scoreboard and write-to-read bypass.
- Provides two read ports and one write port.
- Sits in the decode stage of the core: decode reads operands and busy flags and marks destination registers busy at issue; writeback writes results and clears busy.
- Supersedes the fixed 32-entry file. Adds width and depth parametrisation, async reset of contents, forwarding, and an optional registered-read mode.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers (power of 2, 2..64).
- AW, $clog2(NUM_REGS), address width (derived; not overridden).
- READ_REG, 0, 0 = combinational read ports; 1 = read data and busy registered (1-cycle latency).
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr1_i  input  AW  read port 1 address
- rd_addr2_i  input  AW  read port 2 address
- rd_data1_o  output  XLEN  read port 1 data
- rd_data2_o  output  XLEN  read port 2 data
- rd_busy1_o  output  1  register at rd_addr1_i has a pending producer
- rd_busy2_o  output  1  register at rd_addr2_i has a pending producer
- wr_en_i  input  1  writeback valid
- wr_addr_i  input  AW  writeback destination
- wr_data_i  input  XLEN  writeback data
- iss_en_i  input  1  issue valid: mark iss_addr_i busy
- iss_addr_i  input  AW  issued instruction destination
- busy_any_o  output  1  OR of all busy bits (drain/flush indicator)

Behaviour:
- Reset (rst=1, asynchronous): all NUM_REGS data entries = 0, all busy bits = 0. When READ_REG=1, rd_data*/rd_busy* registers = 0. busy_any_o = 0.
- Write: on posedge with wr_en_i=1, reg[wr_addr_i] <= wr_data_i and busy[wr_addr_i] <= 0. Exception: with ZERO_REG=1 and wr_addr_i=0, the write is dropped.
- Issue: on posedge with iss_en_i=1, busy[iss_addr_i] <= 1. Exception: with ZERO_REG=1 and iss_addr_i=0, the issue is ignored.
- Same-cycle write and issue to the same address: data written; busy ends at 1 (the new producer wins).
- Write and issue to different addresses in the same cycle: both take effect independently.
- Write to a register that is not busy: legal; data updated, busy stays 0.
- Issue to an already-busy register: busy stays 1 (no counting; one outstanding producer tracked per register).
- Read data, per port p (READ_REG=0, combinational):
  - ZERO_REG=1 and rd_addr=0: data = 0, busy = 0.
  - Else if wr_en_i and wr_addr_i==rd_addr (bypass): data = wr_data_i, busy = 0.
  - Else: data = reg[rd_addr], busy = busy[rd_addr].
- Bypass does not consider same-cycle iss_en_i; the issue is visible on busy the following cycle.
- READ_REG=1: the same combinational result is captured at posedge and presented the next cycle. Latency is exactly 1 cycle from address to data. Bypass remains active, so the captured value includes a same-cycle write.
- Both read ports may address the same register; the results are identical.
- busy_any_o: combinational OR of the busy array (post-state, not bypassed).
- No X propagation: all addresses in 0..NUM_REGS-1 are valid, so out-of-range addresses cannot occur by construction.
- Reset asserted mid-operation: contents and busy clear immediately. Writes and issues in the cycle of reset deassertion take effect at the first posedge after rst falls.

Test Plan:
- Reset then read all addresses on both ports -> every rd_data = 0, rd_busy = 0, busy_any_o = 0. Assert rst mid-run after writes -> same.
- Write 0xDEADBEEF to r5, next cycle read r5 on port 1 and r5 on port 2 -> both 0xDEADBEEF. Write 0x1234 to r0 (ZERO_REG=1) -> r0 reads 0.
- Bypass: wr_en_i=1, wr_addr_i=7, wr_data_i=0xA5A5A5A5 with rd_addr1_i=7 in the same cycle -> rd_data1_o=0xA5A5A5A5 combinationally (READ_REG=0), or on the next cycle (READ_REG=1).
- Scoreboard: issue r3 -> next cycle rd_busy=1 for r3, busy_any_o=1. Write r3=0x55 -> rd_busy=0 in the same cycle via bypass; stored busy clears at the posedge.
- Simultaneous issue r9 and write r9=0x77 -> next cycle r9 reads 0x77, busy=1. Issue r0 -> busy stays 0.
- Parameter sweep: XLEN=64, NUM_REGS=16, READ_REG=1 -> write 0xFFFF_0000_FFFF_0000 to r15, read r15 -> value appears exactly 1 cycle after the address is applied. Random issue/write stress vs. a reference model shows no mismatches.
